// File: rtl/pulse_pkg.sv
// Shared definitions for the pulse stretcher: FSM state encoding and
// the helper that sizes the shared down-counter.
package pulse_pkg;

  // FSM states. Encoding 2'b11 is unused and recovers to ST_IDLE.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_HIGH = 2'b01,
    ST_HOLD = 2'b10
  } state_t;

  // Counter width: wide enough to hold WIDTH-1 and HOLDOFF-1, never
  // narrower than one bit.
  function automatic int cnt_width(input int width, input int holdoff);
    int m;
    m = (width > holdoff) ? width : holdoff;
    if (m < 2) begin
      m = 2;
    end else begin
      m = m;
    end
    return $clog2(m);
  endfunction

endpackage : pulse_pkg

// File: rtl/pulse_stretcher.sv
// Pulse stretcher: turns a one-cycle tick into a level pulse exactly WIDTH
// cycles long, followed by a forced-low holdoff of HOLDOFF cycles. A single
// down-counter times both the high phase and the holdoff phase. Also emits
// registered rise/fall ticks, a busy indication and a missed-tick flag.
module pulse_stretcher
  import pulse_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int HOLDOFF   = 2,
  parameter int RETRIGGER = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  output logic level,
  output logic rise,
  output logic fall,
  output logic busy,
  output logic missed
);

  localparam int CW = cnt_width(WIDTH, HOLDOFF);

  // Reload values for the two timed phases.
  localparam logic [CW-1:0] WIDTH_LOAD = CW'(WIDTH - 1);
  localparam logic [CW-1:0] HOLD_LOAD  = CW'((HOLDOFF > 0) ? (HOLDOFF - 1) : 0);
  localparam logic [CW-1:0] CNT_ZERO   = CW'(0);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam bit            RETRIG     = (RETRIGGER != 0);
  localparam bit            HAS_HOLD   = (HOLDOFF > 0);

  state_t        state;
  logic [CW-1:0] cnt;
  logic          rise_r;
  logic          fall_r;
  logic          missed_r;

  // Main FSM: state, shared counter and the registered event ticks.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      cnt      <= CNT_ZERO;
      rise_r   <= 1'b0;
      fall_r   <= 1'b0;
      missed_r <= 1'b0;
    end else begin
      // Event ticks are single-cycle unless re-armed below.
      rise_r   <= 1'b0;
      fall_r   <= 1'b0;
      missed_r <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (tick) begin
            state  <= ST_HIGH;
            cnt    <= WIDTH_LOAD;
            rise_r <= 1'b1;
          end else begin
            state  <= ST_IDLE;
            cnt    <= cnt;
          end
        end

        ST_HIGH: begin
          if (cnt != CNT_ZERO) begin
            // Still inside the high window.
            if (tick && RETRIG) begin
              cnt <= WIDTH_LOAD;
            end else begin
              cnt      <= cnt - CNT_ONE;
              missed_r <= tick;
            end
          end else if (tick && RETRIG) begin
            // Last high cycle but retriggered: extend without a new rise.
            cnt <= WIDTH_LOAD;
          end else begin
            // Pulse ends; a tick arriving now cannot start a new one.
            fall_r   <= 1'b1;
            missed_r <= tick;
            if (HAS_HOLD) begin
              state <= ST_HOLD;
              cnt   <= HOLD_LOAD;
            end else begin
              state <= ST_IDLE;
              cnt   <= CNT_ZERO;
            end
          end
        end

        ST_HOLD: begin
          if (cnt != CNT_ZERO) begin
            cnt      <= cnt - CNT_ONE;
            missed_r <= tick;
          end else if (tick) begin
            // Last holdoff cycle: accept so the low time is exactly HOLDOFF.
            state  <= ST_HIGH;
            cnt    <= WIDTH_LOAD;
            rise_r <= 1'b1;
          end else begin
            state <= ST_IDLE;
            cnt   <= CNT_ZERO;
          end
        end

        default: begin
          state <= ST_IDLE;
          cnt   <= CNT_ZERO;
        end
      endcase
    end
  end

  // Moore decodes of the state register.
  assign level  = (state == ST_HIGH);
  assign busy   = (state != ST_IDLE);
  assign rise   = rise_r;
  assign fall   = fall_r;
  assign missed = missed_r;

endmodule : pulse_stretcher

// File: tb/tb_pulse_stretcher.sv
// Self-checking bench for pulse_stretcher. Three instances cover the
// default configuration, RETRIGGER=1 and HOLDOFF=0. Expected waveforms are
// hand-derived edge masks pushed into a scoreboard as stimulus is driven;
// sampled DUT outputs are queued after each edge and compared per scenario.
module tb_pulse_stretcher;

  typedef struct packed {
    logic level;
    logic rise;
    logic fall;
    logic busy;
    logic missed;
  } obs_t;

  logic clk;
  logic reset;
  logic tick_a, tick_b, tick_c;
  logic level_a, rise_a, fall_a, busy_a, missed_a;
  logic level_b, rise_b, fall_b, busy_b, missed_b;
  logic level_c, rise_c, fall_c, busy_c, missed_c;

  int n_cmp;
  int n_err;

  obs_t exp_q[$];
  obs_t obs_q[$];
  int   edge_q[$];

  pulse_stretcher #(.WIDTH(4), .HOLDOFF(2), .RETRIGGER(0)) dut_a (
    .clk(clk), .reset(reset), .tick(tick_a), .level(level_a),
    .rise(rise_a), .fall(fall_a), .busy(busy_a), .missed(missed_a));

  pulse_stretcher #(.WIDTH(4), .HOLDOFF(2), .RETRIGGER(1)) dut_b (
    .clk(clk), .reset(reset), .tick(tick_b), .level(level_b),
    .rise(rise_b), .fall(fall_b), .busy(busy_b), .missed(missed_b));

  pulse_stretcher #(.WIDTH(4), .HOLDOFF(0), .RETRIGGER(0)) dut_c (
    .clk(clk), .reset(reset), .tick(tick_c), .level(level_c),
    .rise(rise_c), .fall(fall_c), .busy(busy_c), .missed(missed_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Mask with bits lo..hi set.
  function automatic logic [63:0] rng(input int lo, input int hi);
    logic [63:0] m;
    m = 64'd0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  function automatic logic [63:0] bitm(input int b);
    return rng(b, b);
  endfunction

  function automatic obs_t sample(input int sel);
    obs_t o;
    case (sel)
      0: o = '{level_a, rise_a, fall_a, busy_a, missed_a};
      1: o = '{level_b, rise_b, fall_b, busy_b, missed_b};
      default: o = '{level_c, rise_c, fall_c, busy_c, missed_c};
    endcase
    return o;
  endfunction

  task automatic drive_tick(input int sel, input logic v);
    tick_a = (sel == 0) ? v : 1'b0;
    tick_b = (sel == 1) ? v : 1'b0;
    tick_c = (sel == 2) ? v : 1'b0;
  endtask

  // Reset all instances and release at a falling edge; next posedge is edge 1.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    drive_tick(0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Drive edges first..last; push expected at drive time, observed after edge.
  task automatic run_seq(input int sel, input logic [63:0] tm,
                         input logic [63:0] lv, input logic [63:0] ri,
                         input logic [63:0] fa, input logic [63:0] bu,
                         input logic [63:0] mi, input int first, input int last);
    obs_t e;
    for (int n = first; n <= last; n++) begin
      drive_tick(sel, tm[n]);
      e = '{lv[n], ri[n], fa[n], bu[n], mi[n]};
      exp_q.push_back(e);
      edge_q.push_back(n);
      @(posedge clk);
      #1;
      obs_q.push_back(sample(sel));
      @(negedge clk);
    end
    drive_tick(sel, 1'b0);
  endtask

  task automatic test_reset();
    obs_t o;
    @(negedge clk);
    reset = 1'b1;
    drive_tick(0, 1'b0);
    #1;
    for (int s = 0; s < 3; s++) begin
      o = sample(s);
      n_cmp++;
      if (o !== 5'b00000) begin
        n_err++;
        $display("FAIL reset dut%0d: got lvl/rise/fall/busy/miss=%b expected 00000", s, o);
      end
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_basic();
    obs_t e, o;
    int n;
    do_reset();
    run_seq(0, bitm(10), rng(10, 13), bitm(10), bitm(14), rng(10, 15), 64'd0, 1, 20);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n = edge_q.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL basic edge %0d: got %b expected %b", n, o, e);
      end
    end
  endtask

  task automatic test_holdoff();
    obs_t e, o;
    int n;
    do_reset();
    run_seq(0, bitm(10) | bitm(12) | bitm(15) | bitm(16),
            rng(10, 13) | rng(16, 19), bitm(10) | bitm(16),
            bitm(14) | bitm(20), rng(10, 21), bitm(12) | bitm(15), 1, 24);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n = edge_q.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL holdoff edge %0d: got %b expected %b", n, o, e);
      end
    end
  endtask

  task automatic test_retrigger();
    obs_t e, o;
    int n;
    do_reset();
    run_seq(1, bitm(10) | bitm(12), rng(10, 15), bitm(10), bitm(16),
            rng(10, 17), 64'd0, 1, 20);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n = edge_q.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL retrigger edge %0d: got %b expected %b", n, o, e);
      end
    end
  endtask

  task automatic test_holdoff_zero();
    obs_t e, o;
    int n;
    do_reset();
    run_seq(2, bitm(10) | bitm(14) | bitm(15),
            rng(10, 13) | rng(15, 18), bitm(10) | bitm(15),
            bitm(14) | bitm(19), rng(10, 13) | rng(15, 18), bitm(14), 1, 22);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n = edge_q.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL holdoff0 edge %0d: got %b expected %b", n, o, e);
      end
    end
  endtask

  task automatic test_reset_mid_pulse();
    obs_t e, o;
    int n;
    logic [63:0] tm, lv, ri, fa, bu;
    tm = bitm(10) | bitm(20);
    lv = rng(10, 11) | rng(20, 23);
    ri = bitm(10) | bitm(20);
    fa = bitm(24);
    bu = rng(10, 11) | rng(20, 25);
    do_reset();
    run_seq(0, tm, lv, ri, fa, bu, 64'd0, 1, 11);
    // Asynchronous reset halfway between edges 11 and 12.
    reset = 1'b1;
    #1;
    o = sample(0);
    n_cmp++;
    if (o !== 5'b00000) begin
      n_err++;
      $display("FAIL reset_mid async: got %b expected 00000", o);
    end
    @(negedge clk);
    reset = 1'b0;
    run_seq(0, tm, lv, ri, fa, bu, 64'd0, 13, 30);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n = edge_q.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL reset_mid edge %0d: got %b expected %b", n, o, e);
      end
    end
  endtask

  task automatic test_continuous();
    obs_t e, o;
    int n;
    do_reset();
    run_seq(0, rng(10, 30),
            rng(10, 13) | rng(16, 19) | rng(22, 25) | rng(28, 31),
            bitm(10) | bitm(16) | bitm(22) | bitm(28),
            bitm(14) | bitm(20) | bitm(26) | bitm(32),
            rng(10, 33),
            rng(11, 15) | rng(17, 21) | rng(23, 27) | rng(29, 30), 1, 36);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n = edge_q.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL continuous edge %0d: got %b expected %b", n, o, e);
      end
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_err  = 0;
    reset  = 1'b1;
    tick_a = 1'b0;
    tick_b = 1'b0;
    tick_c = 1'b0;
    test_reset();
    test_basic();
    test_holdoff();
    test_retrigger();
    test_holdoff_zero();
    test_reset_mid_pulse();
    test_continuous();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_pulse_stretcher

// File: doc/pulse_stretcher.md
Name: pulse_stretcher

Overview:
- Converts a one-cycle tick into a level pulse exactly WIDTH cycles long, followed by an enforced low holdoff of HOLDOFF cycles. This is the inverse direction of the rising-edge detector.
- Drives LEDs, enables and strobes that need a visible or minimum-width level.
- Moore FSM with a shared down-counter. Also emits rise/fall ticks, busy, and a missed-tick flag.

Parameters:
- WIDTH, 4, high time in clk cycles; legal range >= 1.
- HOLDOFF, 2, forced-low cycles after each pulse; legal range >= 0.
- RETRIGGER, 0. 1 = a tick while high restarts the WIDTH count. 0 = that tick is dropped.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  reset, asynchronous, active-high.
- tick  input  1  synchronous request; sampled every rising clk edge; may be high several cycles.
- level  output  1  stretched pulse; Moore output, equals (state==HIGH).
- rise  output  1  registered; one cycle high in the first cycle of each new pulse. Not asserted on a retrigger.
- fall  output  1  registered; one cycle high in the first cycle after level drops.
- busy  output  1  high whenever state != IDLE.
- missed  output  1  registered; high the cycle after a tick is dropped.

Behaviour:
- Reset (async) forces state=IDLE and cnt=0. level, rise, fall, busy and missed all go 0 immediately, including mid-pulse. No fall tick is generated by reset.
- States and counter: IDLE, HIGH, HOLD. cnt width is $clog2 of max(WIDTH, HOLDOFF, 2).
- IDLE:
  - tick -> HIGH, cnt=WIDTH-1, rise=1 next cycle.
  - otherwise stay in IDLE.
- HIGH, cnt != 0:
  - tick with RETRIGGER=1 -> cnt=WIDTH-1.
  - tick with RETRIGGER=0 -> cnt-1, missed=1.
  - no tick -> cnt-1.
- HIGH, cnt == 0:
  - tick with RETRIGGER=1 -> cnt=WIDTH-1, stay HIGH.
  - Otherwise: HOLDOFF>0 -> HOLD with cnt=HOLDOFF-1; HOLDOFF==0 -> IDLE. fall=1 next cycle.
  - Any tick here with RETRIGGER=0 is dropped, missed=1.
- HOLD, cnt != 0: cnt-1. A tick is dropped, missed=1.
- HOLD, cnt == 0 (last holdoff cycle):
  - tick -> HIGH, cnt=WIDTH-1, rise=1. The low time is then exactly HOLDOFF cycles.
  - otherwise -> IDLE.
- Latency: a tick sampled at edge N gives level=1 after edge N. level stays high exactly WIDTH cycles (no retrigger).
- rise, fall and missed are never high for two consecutive cycles from a single event.
- A continuously high tick:
  - RETRIGGER=1: level stays high.
  - RETRIGGER=0: repeating pulse of WIDTH high, then HOLDOFF low (minimum 1 low cycle when HOLDOFF=0), with missed asserted on each dropped cycle.
- Unused state encoding -> IDLE.

Decomposition:
- Shared package pulse_pkg:
  - state localparams ST_IDLE=2'b00, ST_HIGH=2'b01, ST_HOLD=2'b10.
  - function for the counter width.
- Single module. The counter is inline (one always block per register group). No sub-module.

Test Plan (WIDTH=4, HOLDOFF=2, RETRIGGER=0 unless noted):
- Basic pulse:
  - Stimulus: reset, release; tick 1 cycle at edge 10.
  - Response: level=1 after edges 10–13, 0 after edge 14. rise=1 only after edge 10. fall=1 only after edge 14. busy=0 after edge 16. missed stays 0.
- Holdoff:
  - Stimulus: tick at edge 10, then at 12, 15 and 16.
  - Response: ticks at 12 and 15 are dropped, with missed=1 after edges 12 and 15. Tick at 16 is accepted: level=1 after edge 16, with exactly 2 low cycles (after 14, 15). rise=1 after 16.
- Retrigger (RETRIGGER=1):
  - Stimulus: ticks at edges 10 and 12.
  - Response: level=1 after edges 10–15, low after 16. rise once (after 10). fall after 16. missed never set.
- HOLDOFF=0:
  - Stimulus: ticks at edges 10, 14, 15.
  - Response: tick at 14 is dropped (missed after 14). level low exactly 1 cycle (after 14). Tick at 15 starts a new pulse: level=1 after edges 15–18.
- Reset mid-pulse:
  - Stimulus: tick at 10; reset asserted asynchronously between edges 11 and 12 for 1 cycle; then tick at 20.
  - Response: level, busy and all ticks go 0 immediately, with no fall. Clean 4-cycle pulse after edge 20.
- Continuous tick:
  - Stimulus: tick held high from edge 10 to 30.
  - Response: level pattern 4 high / 2 low repeating from edge 10. missed=1 on every dropped cycle.
